alarma_timer_ctrl: RTL

ALARMA_TIMER_CTRL -- requirements
Module: alarma_timer_ctrl

---
 rtl/alarma_timer_ctrl_pkg.sv | 38 +++
 rtl/sincronizador_flanco.sv | 37 +++
 rtl/alarma_timer_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alarma_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarma_timer_ctrl_pkg
//  Description : Shared definitions for the alarm/timer controller: default
//                timing parameters, 2-bit state encoding and a counter-width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarma_timer_ctrl_pkg;

    // Default timing for a 100 MHz system clock
    localparam int unsigned DEF_CLK_HZ          = 100000000;
    localparam int unsigned DEF_BLINK_HALF      = 25000000;
    localparam int unsigned DEF_ALARM_TIMEOUT_S = 60;

    // Controller state encoding
    localparam logic [1:0] ST_ESPERA_CONF = 2'd0;
    localparam logic [1:0] ST_CONF        = 2'd1;
    localparam logic [1:0] ST_TIMER_RUN   = 2'd2;
    localparam logic [1:0] ST_ALARMA_ON   = 2'd3;

    typedef enum logic [1:0] {
        ESPERA_CONF = ST_ESPERA_CONF,
        CONF        = ST_CONF,
        TIMER_RUN   = ST_TIMER_RUN,
        ALARMA_ON   = ST_ALARMA_ON
    } estado_t;

    // Bits needed for a counter holding values 0..n-1 (never less than 1)
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : alarma_timer_ctrl_pkg
`default_nettype wire

// File: rtl/sincronizador_flanco.sv
`default_nettype none
// ============================================================================
//  Module      : sincronizador_flanco
//  Description : Two-flop synchronizer for an asynchronous level input plus a
//                rising-edge detector producing a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_flanco (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Metastability chain followed by a one-cycle delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule : sincronizador_flanco
`default_nettype wire

// File: rtl/alarma_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarma_timer_ctrl
//  Description : Alarm/timer controller. Lets the user configure a target
//                time, starts the RTC timer, raises the alarm when the running
//                timer matches the target, blinks while active and clears on
//                button press or after a timeout in seconds.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarma_timer_ctrl
    import alarma_timer_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
    parameter int unsigned BLINK_HALF      = DEF_BLINK_HALF,
    parameter int unsigned ALARM_TIMEOUT_S = DEF_ALARM_TIMEOUT_S
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_config,
    input  logic       desactivar_alarma,
    input  logic [7:0] out_seg_timer,
    input  logic [7:0] out_min_timer,
    input  logic [7:0] out_hora_timer,
    input  logic [7:0] count_seg_timer,
    input  logic [7:0] count_min_timer,
    input  logic [7:0] count_hora_timer,
    output logic       flag_mostrar_count,
    output logic       estado_alarma,
    output logic       alarm_blink,
    output logic       start_timer
);

    localparam int unsigned PRESC_W = cnt_width(CLK_HZ);
    localparam int unsigned BLINK_W = cnt_width(BLINK_HALF);
    localparam int unsigned TOUT_W  = cnt_width(ALARM_TIMEOUT_S + 1);

    localparam logic [PRESC_W-1:0] C_PRESC_LAST = PRESC_W'(CLK_HZ - 1);
    localparam logic [BLINK_W-1:0] C_BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [TOUT_W-1:0]  C_TOUT_MAX   = TOUT_W'(ALARM_TIMEOUT_S);
    localparam logic [TOUT_W-1:0]  C_TOUT_PRE   =
        (ALARM_TIMEOUT_S > 0) ? TOUT_W'(ALARM_TIMEOUT_S - 1) : '0;

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic sw_sync;
    logic sw_rise_unused;
    logic des_sync_unused;
    logic des_p;

    sincronizador_flanco u_sync_sw (
        .clk     (clk),
        .reset   (reset),
        .async_i (sw_config),
        .sync_o  (sw_sync),
        .rise_o  (sw_rise_unused)
    );

    sincronizador_flanco u_sync_des (
        .clk     (clk),
        .reset   (reset),
        .async_i (desactivar_alarma),
        .sync_o  (des_sync_unused),
        .rise_o  (des_p)
    );

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    estado_t              state_q, state_d;
    logic                 flag_done_q, flag_done_d;
    logic                 start_q, start_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [TOUT_W-1:0]    tout_q, tout_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_q, blink_d;

    logic                 time_match;
    logic                 target_nonzero;
    logic                 sec_tick;
    logic                 timeout_hit;

    // Raw byte compare of running timer against the user target
    assign time_match     = (out_seg_timer  == count_seg_timer)
                          && (out_min_timer  == count_min_timer)
                          && (out_hora_timer == count_hora_timer);
    assign target_nonzero = |{count_hora_timer, count_min_timer, count_seg_timer};

    // One-second tick, meaningful only while the alarm is on
    assign sec_tick    = (presc_q == C_PRESC_LAST);

    // Timeout fires on the tick that brings the seconds count to its limit
    assign timeout_hit = (tout_q == C_TOUT_MAX)
                       || (sec_tick && (tout_q == C_TOUT_PRE));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ESPERA_CONF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and Moore outputs
    always_comb begin
        state_d            = state_q;
        flag_mostrar_count = 1'b1;
        estado_alarma      = 1'b0;
        case (state_q)
            ESPERA_CONF: begin
                if (sw_sync) begin
                    state_d = CONF;
                end
            end
            CONF: begin
                if (!sw_sync) begin
                    state_d = TIMER_RUN;
                end
            end
            TIMER_RUN: begin
                flag_mostrar_count = 1'b0;
                // A new configuration request wins over a simultaneous match
                if (sw_sync) begin
                    state_d = CONF;
                end else if (flag_done_q) begin
                    state_d = ALARMA_ON;
                end
            end
            ALARMA_ON: begin
                estado_alarma = 1'b1;
                if (des_p || timeout_hit) begin
                    state_d = ESPERA_CONF;
                end
            end
            default: begin
                state_d = ESPERA_CONF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Match flag and start pulse
    // ------------------------------------------------------------------

    // Next values: match only counts while running; start marks CONF exit
    always_comb begin
        flag_done_d = (state_q == TIMER_RUN) && time_match && target_nonzero;
        start_d     = (state_q == CONF) && !sw_sync;
    end

    // Registered match flag and start pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            flag_done_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            flag_done_q <= flag_done_d;
            start_q     <= start_d;
        end
    end

    // ------------------------------------------------------------------
    // Seconds prescaler and alarm timeout counter
    // ------------------------------------------------------------------

    // Counters run only in ALARMA_ON and sit at zero otherwise
    always_comb begin
        presc_d = '0;
        tout_d  = '0;
        if (state_q == ALARMA_ON) begin
            if (sec_tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
            tout_d = tout_q;
            if (sec_tick && (tout_q != C_TOUT_MAX)) begin
                tout_d = tout_q + TOUT_W'(1);
            end
        end
    end

    // Prescaler and timeout registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
            tout_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tout_q  <= tout_d;
        end
    end

    // ------------------------------------------------------------------
    // Blink generator
    // ------------------------------------------------------------------

    // Blink starts high on entry, toggles every BLINK_HALF cycles, low elsewhere
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_d == ALARMA_ON) begin
            if (state_q != ALARMA_ON) begin
                blink_cnt_d = '0;
                blink_d     = 1'b1;
            end else if (blink_cnt_q == C_BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_d     = blink_q;
            end
        end
    end

    // Blink registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign alarm_blink = blink_q;
    assign start_timer = start_q;

endmodule : alarma_timer_ctrl
`default_nettype wire
